// File: rtl/wbs_spi_bridge.sv
// rtl/wbs_spi_bridge.sv - Pipelined Wishbone slave feeding SPI TX/RX FIFOs plus a config register bank
module wbs_spi_bridge #(
   parameter int reset_polarity_g = 0,
   parameter int data_width_g     = 8,
   parameter int blen_width_g     = 9,
   parameter int addr_width_g     = 10,
   parameter int reg_din_width_g  = 8,
   parameter int fifo_log_g       = 4
) (
   input  logic                       clock,
   input  logic                       rst,
   input  logic                       wbs_cyc_i,
   input  logic                       wbs_stb_i,
   input  logic                       wbs_we_i,
   input  logic [addr_width_g-1:0]    wbs_adr_i,
   input  logic [blen_width_g-1:0]    wbs_tga_i,
   input  logic [data_width_g-1:0]    wbs_dat_i,
   input  logic                       wbs_tgc_i,
   input  logic                       wbs_tgd_i,
   output logic [data_width_g-1:0]    wbs_dat_o,
   output logic                       wbs_stall_o,
   output logic                       wbs_ack_o,
   output logic                       wbs_err_o,
   output logic [data_width_g-1:0]    tx_dout,
   output logic                       tx_tgd,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   input  logic [data_width_g-1:0]    rx_din,
   input  logic                       rx_valid,
   output logic                       rx_ready,
   output logic                       cfg_cpol,
   output logic                       cfg_cpha,
   output logic [reg_din_width_g-1:0] cfg_div,
   output logic [reg_din_width_g-1:0] cfg_ss
);
   localparam int depth = 1 << fifo_log_g;
   localparam logic [fifo_log_g:0] full_cnt = (fifo_log_g + 1)'(depth);

   typedef enum logic [1:0] {IDLE, WR_DATA, RD_DATA, REG} state_t;

   logic rst_n;
   assign rst_n = (reset_polarity_g != 0) ? ~rst : rst;

   logic unused_adr;
   assign unused_adr = ^wbs_adr_i[addr_width_g-1:2];

   state_t                  state, state_nxt, target;
   logic [blen_width_g-1:0] cnt, cnt_nxt, eff_cnt;
   logic                    done, done_nxt;
   logic                    req, beat, overrun, reg_hit, reg_bad;
   logic                    tx_push, tx_pop, tx_full, tx_empty;
   logic                    rx_push, rx_pop, rx_full, rx_empty;
   logic [fifo_log_g:0]     tx_wptr, tx_rptr, rx_wptr, rx_rptr;
   logic [data_width_g:0]   tx_mem [depth];
   logic [data_width_g-1:0] rx_mem [depth];
   logic [reg_din_width_g-1:0] reg0;

   // TX FIFO carries {tgd, data}; pointers have one extra bit to tell full from empty
   assign tx_empty = (tx_wptr == tx_rptr);
   assign tx_full  = ((tx_wptr - tx_rptr) == full_cnt);
   assign tx_valid = !tx_empty;
   assign tx_pop   = tx_valid & tx_ready;
   assign {tx_tgd, tx_dout} = tx_mem[tx_rptr[fifo_log_g-1:0]];

   assign rx_empty = (rx_wptr == rx_rptr);
   assign rx_full  = ((rx_wptr - rx_rptr) == full_cnt);
   assign rx_ready = !rx_full;
   assign rx_push  = rx_valid & rx_ready;

   always_ff @(posedge clock) begin
      if (tx_push) tx_mem[tx_wptr[fifo_log_g-1:0]] <= {wbs_tgd_i, wbs_dat_i};
      if (rx_push) rx_mem[rx_wptr[fifo_log_g-1:0]] <= rx_din;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
         rx_wptr <= '0;
         rx_rptr <= '0;
      end else begin
         if (tx_push) tx_wptr <= tx_wptr + 1'b1;
         if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
         if (rx_push) rx_wptr <= rx_wptr + 1'b1;
         if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         done  <= done_nxt;
      end
   end

   // In IDLE the first beat is decoded straight from the bus so it can be taken without a bubble
   always_comb begin
      target      = state;
      if (state == IDLE) begin
         if (wbs_tgc_i)     target = REG;
         else if (wbs_we_i) target = WR_DATA;
         else               target = RD_DATA;
      end
      req         = wbs_cyc_i & wbs_stb_i;
      wbs_stall_o = 1'b0;
      if (!done && (req || state != IDLE))
         wbs_stall_o = ((target == WR_DATA) & tx_full) | ((target == RD_DATA) & rx_empty);
      beat        = req & !wbs_stall_o & !done;
      overrun     = req & done;
      reg_hit     = beat & (target == REG);
      reg_bad     = reg_hit & (wbs_adr_i[1:0] == 2'd3);
      tx_push     = beat & (target == WR_DATA);
      rx_pop      = beat & (target == RD_DATA);
      eff_cnt     = (state == IDLE) ? wbs_tga_i : cnt;

      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = done;
      if (!wbs_cyc_i) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         done_nxt  = 1'b0;
      end else if (beat) begin
         if (eff_cnt == '0) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
         end else begin
            state_nxt = target;
            cnt_nxt   = eff_cnt - 1'b1;
         end
      end else if (state == IDLE && req && !done) begin
         state_nxt = target;
         cnt_nxt   = wbs_tga_i;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wbs_ack_o <= 1'b0;
         wbs_err_o <= 1'b0;
         wbs_dat_o <= '0;
         reg0      <= '0;
         cfg_div   <= reg_din_width_g'(4);
         cfg_ss    <= '1;
      end else begin
         wbs_ack_o <= beat & !reg_bad;
         wbs_err_o <= overrun | reg_bad;
         if (rx_pop) begin
            wbs_dat_o <= rx_mem[rx_rptr[fifo_log_g-1:0]];
         end else if (reg_hit && !wbs_we_i) begin
            case (wbs_adr_i[1:0])
               2'd0:    wbs_dat_o <= data_width_g'(reg0);
               2'd1:    wbs_dat_o <= data_width_g'(cfg_div);
               2'd2:    wbs_dat_o <= data_width_g'(cfg_ss);
               default: wbs_dat_o <= wbs_dat_o;
            endcase
         end
         if (reg_hit && wbs_we_i) begin
            case (wbs_adr_i[1:0])
               2'd0:    reg0    <= reg_din_width_g'(wbs_dat_i);
               2'd1:    cfg_div <= reg_din_width_g'(wbs_dat_i);
               2'd2:    cfg_ss  <= reg_din_width_g'(wbs_dat_i);
               default: reg0    <= reg0;
            endcase
         end
      end
   end

   assign cfg_cpol = reg0[0];
   assign cfg_cpha = reg0[1];
endmodule

// File: tb/tb_wbs_spi_bridge.sv
// tb/tb_wbs_spi_bridge.sv - Directed self-checking bench for wbs_spi_bridge
module tb_wbs_spi_bridge;
   logic       clock = 1'b0;
   logic       rst = 1'b0;
   logic       wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0, wbs_tgc_i = 1'b0, wbs_tgd_i = 1'b0;
   logic [9:0] wbs_adr_i = '0;
   logic [8:0] wbs_tga_i = '0;
   logic [7:0] wbs_dat_i = '0;
   logic [7:0] wbs_dat_o;
   logic       wbs_stall_o, wbs_ack_o, wbs_err_o;
   logic [7:0] tx_dout;
   logic       tx_tgd, tx_valid;
   logic       tx_ready = 1'b0;
   logic [7:0] rx_din = '0;
   logic       rx_valid = 1'b0;
   logic       rx_ready, cfg_cpol, cfg_cpha;
   logic [7:0] cfg_div, cfg_ss;

   int checks = 0;
   int errors = 0;
   int n_ack, n_err, n_acc, lat_bad, tmo;
   logic acc_prev = 1'b0;
   logic [7:0] rd_q[$];
   logic [8:0] tx_q[$];
   bit resp_q[$];

   wbs_spi_bridge dut (
      .clock(clock), .rst(rst),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_adr_i(wbs_adr_i),
      .wbs_tga_i(wbs_tga_i), .wbs_dat_i(wbs_dat_i), .wbs_tgc_i(wbs_tgc_i), .wbs_tgd_i(wbs_tgd_i),
      .wbs_dat_o(wbs_dat_o), .wbs_stall_o(wbs_stall_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
      .tx_dout(tx_dout), .tx_tgd(tx_tgd), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_din(rx_din), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_div(cfg_div), .cfg_ss(cfg_ss)
   );

   always #5 clock = ~clock;

   // Bus observer: logs responses, TX pops and accepted beats; flags any response not exactly one cycle after its beat
   always @(negedge clock) begin
      if (!rst) begin
         acc_prev = 1'b0;
      end else begin
         if (acc_prev !== (wbs_ack_o | wbs_err_o)) lat_bad++;
         if (wbs_ack_o) begin n_ack++; rd_q.push_back(wbs_dat_o); resp_q.push_back(1'b0); end
         if (wbs_err_o) begin n_err++; resp_q.push_back(1'b1); end
         if (tx_valid && tx_ready) tx_q.push_back({tx_tgd, tx_dout});
         acc_prev = wbs_cyc_i & wbs_stb_i & ~wbs_stall_o;
         if (acc_prev) n_acc++;
      end
   end

   task automatic clear_log();
      n_ack = 0; n_err = 0; n_acc = 0; lat_bad = 0;
      rd_q.delete(); tx_q.delete(); resp_q.delete();
   endtask

   task automatic wb_burst(input logic we, input logic tgc, input logic [8:0] tga, input logic [9:0] adr,
                           input int nbeats, input logic [7:0] d0, output int stalls);
      int i, guard;
      stalls = 0; i = 0; guard = 0;
      @(posedge clock); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_tgc_i = tgc;
      wbs_tga_i = tga; wbs_adr_i = adr; wbs_dat_i = d0; wbs_tgd_i = 1'b0;
      while (i < nbeats && guard < 300) begin
         @(negedge clock);
         guard++;
         if (wbs_stall_o) stalls++;
         else i++;
         @(posedge clock); #1;
         wbs_dat_i = d0 + 8'(i);
         wbs_tgd_i = i[0];
      end
      wbs_stb_i = 1'b0;
      if (i < nbeats) tmo++;
      @(negedge clock);
      @(posedge clock); #1;
      wbs_cyc_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", wbs_ack_o); end
      checks++; if (wbs_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", wbs_err_o); end
      checks++; if (wbs_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", wbs_stall_o); end
      checks++; if (wbs_dat_o !== 8'h00) begin errors++; $display("FAIL reset_dat got %h want 00", wbs_dat_o); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
      checks++; if ({cfg_cpha, cfg_cpol} !== 2'b00) begin errors++; $display("FAIL reset_reg0 got %b want 00", {cfg_cpha, cfg_cpol}); end
      checks++; if (cfg_div !== 8'h04) begin errors++; $display("FAIL reset_div got %h want 04", cfg_div); end
      checks++; if (cfg_ss !== 8'hFF) begin errors++; $display("FAIL reset_ss got %h want ff", cfg_ss); end
      @(posedge clock); #1; rst = 1'b1;
      @(negedge clock);
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
   endtask

   task automatic test_write_burst();
      int st, bad;
      logic [8:0] exp;
      tx_ready = 1'b1; clear_log();
      wb_burst(1'b1, 1'b0, 9'd3, 10'd0, 4, 8'h11, st);
      repeat (3) @(negedge clock);
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         exp = {k[0], 8'h11 + 8'(k)};
         if (k >= tx_q.size() || tx_q[k] !== exp) bad++;
      end
      checks++; if (n_ack !== 4) begin errors++; $display("FAIL wr_acks got %0d want 4", n_ack); end
      checks++; if (n_err !== 0) begin errors++; $display("FAIL wr_errs got %0d want 0", n_err); end
      checks++; if (lat_bad !== 0) begin errors++; $display("FAIL wr_latency got %0d late want 0", lat_bad); end
      checks++; if (st !== 0) begin errors++; $display("FAIL wr_stalls got %0d want 0", st); end
      checks++; if (tx_q.size() !== 4) begin errors++; $display("FAIL wr_tx_count got %0d want 4", tx_q.size()); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL wr_tx_order got %0d wrong want 0", bad); end
   endtask

   task automatic test_tx_full();
      int st, bad, acc_at_stall;
      logic still_stalled;
      logic [8:0] exp;
      tx_ready = 1'b0; clear_log();
      acc_at_stall = -1; still_stalled = 1'b0;
      fork
         wb_burst(1'b1, 1'b0, 9'd19, 10'd0, 20, 8'h20, st);
         begin
            for (int k = 0; k < 100; k++) begin
               @(negedge clock);
               if (wbs_stall_o) break;
            end
            acc_at_stall = n_acc;
            repeat (3) @(posedge clock);
            #1; tx_ready = 1'b1;
            @(negedge clock);
            still_stalled = wbs_stall_o;
         end
      join
      repeat (25) @(negedge clock);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         exp = {k[0], 8'h20 + 8'(k)};
         if (k >= tx_q.size() || tx_q[k] !== exp) bad++;
      end
      checks++; if (acc_at_stall !== 16) begin errors++; $display("FAIL full_beats_before_stall got %0d want 16", acc_at_stall); end
      checks++; if (still_stalled !== 1'b1) begin errors++; $display("FAIL full_pop_same_cycle got stall=%b want 1", still_stalled); end
      checks++; if (n_ack !== 20) begin errors++; $display("FAIL full_acks got %0d want 20", n_ack); end
      checks++; if (lat_bad !== 0) begin errors++; $display("FAIL full_latency got %0d late want 0", lat_bad); end
      checks++; if (tx_q.size() !== 20) begin errors++; $display("FAIL full_tx_count got %0d want 20", tx_q.size()); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL full_tx_order got %0d wrong want 0", bad); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL full_drained got tx_valid=%b want 0", tx_valid); end
   endtask

   task automatic test_read_burst();
      int st;
      logic stalled;
      @(posedge clock); #1; rx_valid = 1'b1; rx_din = 8'hA5;
      @(posedge clock); #1; rx_din = 8'h5A;
      @(posedge clock); #1; rx_valid = 1'b0;
      clear_log(); stalled = 1'b0;
      fork
         wb_burst(1'b0, 1'b0, 9'd2, 10'd0, 3, 8'h00, st);
         begin
            repeat (8) @(negedge clock);
            stalled = wbs_stall_o;
            @(posedge clock); #1; rx_valid = 1'b1; rx_din = 8'h3C;
            @(posedge clock); #1; rx_valid = 1'b0;
         end
      join
      repeat (3) @(negedge clock);
      checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL rd_empty_stall got %b want 1", stalled); end
      checks++; if (n_ack !== 3) begin errors++; $display("FAIL rd_acks got %0d want 3", n_ack); end
      checks++; if (lat_bad !== 0) begin errors++; $display("FAIL rd_latency got %0d late want 0", lat_bad); end
      checks++; if (rd_q.size() !== 3) begin errors++; $display("FAIL rd_count got %0d want 3", rd_q.size()); end
      else begin
         checks++; if (rd_q[0] !== 8'hA5) begin errors++; $display("FAIL rd_beat0 got %h want a5", rd_q[0]); end
         checks++; if (rd_q[1] !== 8'h5A) begin errors++; $display("FAIL rd_beat1 got %h want 5a", rd_q[1]); end
         checks++; if (rd_q[2] !== 8'h3C) begin errors++; $display("FAIL rd_beat2 got %h want 3c", rd_q[2]); end
      end
      checks++; if (wbs_dat_o !== 8'h3C) begin errors++; $display("FAIL rd_dat_hold got %h want 3c", wbs_dat_o); end
   endtask

   task automatic test_regs();
      int st;
      clear_log();
      wb_burst(1'b1, 1'b1, 9'd0, 10'd1, 1, 8'h10, st);
      checks++; if (cfg_div !== 8'h10) begin errors++; $display("FAIL reg_div_write got %h want 10", cfg_div); end
      wb_burst(1'b1, 1'b1, 9'd0, 10'd0, 1, 8'h03, st);
      checks++; if ({cfg_cpha, cfg_cpol} !== 2'b11) begin errors++; $display("FAIL reg0_write got %b want 11", {cfg_cpha, cfg_cpol}); end
      rd_q.delete();
      wb_burst(1'b0, 1'b1, 9'd0, 10'd1, 1, 8'h00, st);
      checks++; if (rd_q.size() !== 1 || rd_q[0] !== 8'h10) begin errors++; $display("FAIL reg_div_read got n=%0d dat=%h want 1 beat of 10", rd_q.size(), wbs_dat_o); end
      n_ack = 0; n_err = 0;
      wb_burst(1'b1, 1'b1, 9'd0, 10'd3, 1, 8'h77, st);
      checks++; if (n_err !== 1) begin errors++; $display("FAIL reg3_err got %0d want 1", n_err); end
      checks++; if (n_ack !== 0) begin errors++; $display("FAIL reg3_ack got %0d want 0", n_ack); end
      checks++; if ({cfg_div, cfg_ss} !== 16'h10FF) begin errors++; $display("FAIL reg3_no_update got %h want 10ff", {cfg_div, cfg_ss}); end
      checks++; if (lat_bad !== 0) begin errors++; $display("FAIL reg_latency got %0d late want 0", lat_bad); end
   endtask

   task automatic test_overrun();
      int st;
      tx_ready = 1'b0; clear_log();
      wb_burst(1'b1, 1'b0, 9'd1, 10'd0, 3, 8'h50, st);
      checks++; if (n_ack !== 2) begin errors++; $display("FAIL ovr_acks got %0d want 2", n_ack); end
      checks++; if (n_err !== 1) begin errors++; $display("FAIL ovr_errs got %0d want 1", n_err); end
      checks++; if (resp_q.size() !== 3 || resp_q[0] !== 1'b0 || resp_q[1] !== 1'b0 || resp_q[2] !== 1'b1)
         begin errors++; $display("FAIL ovr_order got %0d responses want ack,ack,err", resp_q.size()); end
      tx_ready = 1'b1;
      repeat (4) @(negedge clock);
      checks++; if (tx_q.size() !== 2) begin errors++; $display("FAIL ovr_tx_count got %0d want 2", tx_q.size()); end
      else begin
         checks++; if (tx_q[0] !== 9'h050 || tx_q[1] !== 9'h151) begin errors++; $display("FAIL ovr_tx_data got %h %h want 050 151", tx_q[0], tx_q[1]); end
      end
   endtask

   task automatic test_reset_mid();
      int st;
      tx_ready = 1'b0;
      wb_burst(1'b1, 1'b1, 9'd0, 10'd1, 1, 8'h33, st);
      checks++; if (cfg_div !== 8'h33) begin errors++; $display("FAIL mid_pre_div got %h want 33", cfg_div); end
      clear_log();
      @(posedge clock); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_tgc_i = 1'b0;
      wbs_tga_i = 9'd9; wbs_adr_i = '0; wbs_dat_i = 8'h60;
      repeat (5) begin @(posedge clock); #1; wbs_dat_i = wbs_dat_i + 8'd1; end
      wbs_stb_i = 1'b0;
      @(negedge clock); #1;
      checks++; if (n_ack !== 5) begin errors++; $display("FAIL mid_pre_acks got %0d want 5", n_ack); end
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_tx_valid got %b want 1", tx_valid); end
      rst = 1'b0; wbs_stb_i = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL mid_ack_in_reset got %b want 0", wbs_ack_o); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid got %b want 0", tx_valid); end
      checks++; if ({cfg_div, cfg_ss, cfg_cpha, cfg_cpol} !== 18'b00000100_11111111_00)
         begin errors++; $display("FAIL mid_cfg_defaults got %h/%h/%b%b want 04/ff/00", cfg_div, cfg_ss, cfg_cpha, cfg_cpol); end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(posedge clock); #1; rst = 1'b1;
      repeat (4) @(negedge clock);
      checks++; if (n_ack !== 5) begin errors++; $display("FAIL mid_no_more_acks got %0d want 5", n_ack); end
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL mid_rx_ready got %b want 1", rx_ready); end
      checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL mid_tx_popped got %0d want 0", tx_q.size()); end
      checks++; if (tmo !== 0) begin errors++; $display("FAIL bus_timeouts got %0d want 0", tmo); end
   endtask

   initial begin
      tmo = 0;
      clear_log();
      test_reset();
      test_write_burst();
      test_tx_full();
      test_read_burst();
      test_regs();
      test_overrun();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
